// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared types and constants for the multicycle RV32I control unit:
//   FSM state encodings, opcode constants, the ALUOp enum, ALUControl codes
//   and the select codes for ResultSrc / ALUSrcA / ALUSrcB / ImmSrc.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Combinational ALU decoder: turns the FSM's ALUOp request plus the
//   instruction's funct fields into the 3-bit ALUControl code.
// Ports
//   alu_op      in   2  requested operation (add / sub / by funct)
//   funct3      in   3  Instr[14:12]
//   op5         in   1  Instr[5], distinguishes R-type from I-type
//   funct7b5    in   1  Instr[30]
//   alu_control out  3  ALU operation code
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // funct7b5 only selects sub for R-type; addi with imm[10]=1 must stay add.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control unit for the multicycle RV32I datapath: Moore main FSM,
//   immediate-format decoder, ALU decoder instance and a retired-instruction
//   counter. Supports lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal.
// Configuration
//   CTRL_ILLEGAL_TRAP_EN : when defined, an unknown opcode at DECODE traps into
//   a sticky ILLEGAL state (illegal=1) until rst; otherwise it is a NOP.
// Ports
//   clk, rst (synchronous, active-high)
//   op, funct3, funct7b5, zero            instruction fields and ALU flag
//   PCWrite, AdrSrc, MemWrite, IRWrite    datapath enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB           datapath mux selects
//   ALUControl, ImmSrc, RegWrite          ALU op, immediate format, reg write
//   illegal, state, instret               trap flag, debug state, retired count
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUControl,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  aluop_t               alu_op;
  logic                 retire;

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    instret_q <= instret_d;
  end

  // Moore outputs and next state. rst overrides the transition and masks every
  // write enable so an aborted instruction leaves no architectural side effect.
  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_ILLEGAL;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_SUB;
        PCWrite = zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      // jal writes the target into PC here and the link value (OldPC+4) in
      // ALUWB, which is also where it retires.
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      state_d  = S_FETCH;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (rst) begin
      instret_d = '0;
    end else if (retire) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  // Immediate format depends only on the opcode so it is valid in every state.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign state   = state_q;
  assign instret = instret_q;

endmodule
